// File: rtl/program_loader_if.sv
// Program-memory write port shared between the loader (master) and the memory (slave).
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] prog_addr;
    logic [3:0]        prog_wdata;
    logic              prog_we;
    logic              prog_own;

    modport master (output prog_addr, prog_wdata, prog_we, prog_own);
    modport slave  (input  prog_addr, prog_wdata, prog_we, prog_own);
endinterface

// File: rtl/program_loader.sv
// program_loader: collects opcodes from the switches (one per ENTER press) into program
// memory starting at address 0, appends the stop code, then hands memory ownership to
// the control FSM and launches it with a one-cycle go pulse.
// state_dbg encoding: 0 LOAD, 1 TERM, 2 READY, 3 START, 4 WAITLO, 5 RUN.
module program_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [3:0] STOP_CODE = 4'hF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        sw_op,
    input  logic              key_enter,
    input  logic              key_run,
    input  logic              key_clear,
    input  logic              ctrl_idle,
    program_loader_if.master  mem,
    output logic [ADDR_W-1:0] prog_len,
    output logic              go,
    output logic              full,
    output logic              bad_op,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_TERM   = 3'd1,
        S_READY  = 3'd2,
        S_START  = 3'd3,
        S_WAITLO = 3'd4,
        S_RUN    = 3'd5
    } state_e;

    // Last length at which one more user opcode still fits (the next one makes us full).
    localparam logic [ADDR_W-1:0] LAST_USER = {{(ADDR_W-1){1'b1}}, 1'b0};

    // Key vector bit positions.
    localparam int K_ENTER = 0;
    localparam int K_RUN   = 1;
    localparam int K_CLEAR = 2;

    logic [2:0] key_meta_q;
    logic [2:0] key_sync_q;
    logic [2:0] key_prev_q;
    logic [2:0] key_edge_q;
    logic [2:0] key_edge_d;
    logic [1:0] warm_q;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [3:0]        wdata_q;
    logic              we_q;
    logic              own_q;
    logic              full_q;
    logic              go_q;
    logic              bad_q;

    logic enter_edge;
    logic run_edge;
    logic clr_edge;

    // Edges only count once the synchroniser and edge register hold real post-reset
    // samples; otherwise a key held through reset release would look like a fresh press.
    assign key_edge_d = (warm_q == 2'd3) ? (key_sync_q & ~key_prev_q) : 3'b000;

    assign enter_edge = key_edge_q[K_ENTER];
    assign run_edge   = key_edge_q[K_RUN];
    assign clr_edge   = key_edge_q[K_CLEAR];

    // Synchronise the raw keys, remember the previous sample and register detected edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
            key_prev_q <= '0;
            key_edge_q <= '0;
            warm_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's
            // old value, which is what makes this a true multi-flop pipeline.
            key_meta_q <= {key_clear, key_run, key_enter};
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
            key_edge_q <= key_edge_d;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Loader FSM; every output is registered and reflects the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_LOAD;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            own_q   <= 1'b1;
            full_q  <= 1'b0;
            go_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            go_q   <= 1'b0;
            bad_q  <= 1'b0;
            // Outside a user write the address rests on the next free slot.
            addr_q <= len_q;
            case (state_q)
                S_LOAD: begin
                    if (clr_edge) begin
                        len_q  <= '0;
                        addr_q <= '0;
                        full_q <= 1'b0;
                    end else if (run_edge || (enter_edge && sw_op == 4'hF)) begin
                        state_q <= S_TERM;
                        we_q    <= 1'b1;
                        wdata_q <= STOP_CODE;
                    end else if (enter_edge) begin
                        if (sw_op[3]) begin
                            bad_q <= 1'b1;
                        end else if (!full_q) begin
                            we_q    <= 1'b1;
                            wdata_q <= sw_op;
                            len_q   <= len_q + ADDR_W'(1);
                            full_q  <= (len_q == LAST_USER);
                        end
                    end
                end
                S_TERM: begin
                    state_q <= S_READY;
                end
                S_READY: begin
                    if (clr_edge) begin
                        state_q <= S_LOAD;
                        len_q   <= '0;
                        addr_q  <= '0;
                        full_q  <= 1'b0;
                    end else if (run_edge) begin
                        state_q <= S_START;
                        go_q    <= 1'b1;
                        own_q   <= 1'b0;
                    end
                end
                S_START: begin
                    state_q <= S_WAITLO;
                end
                S_WAITLO: begin
                    if (!ctrl_idle) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (ctrl_idle) begin
                        state_q <= S_READY;
                        own_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                    own_q   <= 1'b1;
                end
            endcase
        end
    end

    assign mem.prog_addr  = addr_q;
    assign mem.prog_wdata = wdata_q;
    assign mem.prog_we    = we_q;
    assign mem.prog_own   = own_q;
    assign prog_len       = len_q;
    assign go             = go_q;
    assign full           = full_q;
    assign bad_op         = bad_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (ADDR_W=8 and ADDR_W=2) share one stimulus
// stream; a spec-level model predicts every output each cycle and the expected memory.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] sw_op;
    logic       key_enter, key_run, key_clear, ctrl_idle;

    program_loader_if #(.ADDR_W(8)) if8 ();
    program_loader_if #(.ADDR_W(2)) if2 ();

    logic [7:0] len8;
    logic [1:0] len2;
    logic       go8, go2, full8, full2, bad8, bad2;
    logic [2:0] st8, st2;

    program_loader #(.ADDR_W(8), .STOP_CODE(4'hF)) u_dut8 (
        .clk(clk), .resetn(resetn), .sw_op(sw_op), .key_enter(key_enter),
        .key_run(key_run), .key_clear(key_clear), .ctrl_idle(ctrl_idle), .mem(if8),
        .prog_len(len8), .go(go8), .full(full8), .bad_op(bad8), .state_dbg(st8)
    );

    program_loader #(.ADDR_W(2), .STOP_CODE(4'hF)) u_dut2 (
        .clk(clk), .resetn(resetn), .sw_op(sw_op), .key_enter(key_enter),
        .key_run(key_run), .key_clear(key_clear), .ctrl_idle(ctrl_idle), .mem(if2),
        .prog_len(len2), .go(go2), .full(full2), .bad_op(bad2), .state_dbg(st2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_LOAD, P_TERM, P_READY, P_START, P_WAITLO, P_RUN} phase_t;

    phase_t m_ph[2];
    int     m_len[2], m_waddr[2], m_wdata[2];
    bit     m_we[2], m_go[2], m_bad[2], m_own[2];
    int     m_mem[2][256];
    bit     hq_en[$], hq_run[$], hq_clr[$];

    // A press acts three edges after its first high sample, and only once four real
    // post-reset samples exist (earlier history is unknown and never counts as a press).
    function automatic bit edge_of(input bit cur, input bit prev, input int n);
        return (n >= 5) && cur && !prev;
    endfunction

    task automatic model_step(input int i, input bit e_en, input bit e_run, input bit e_clr);
        int depth;
        depth = (i == 0) ? 256 : 4;
        m_we[i]  = 1'b0;
        m_go[i]  = 1'b0;
        m_bad[i] = 1'b0;
        case (m_ph[i])
            P_LOAD: begin
                if (e_clr) begin
                    m_len[i] = 0;
                end else if (e_run || (e_en && sw_op == 4'hF)) begin
                    m_ph[i]    = P_TERM;
                    m_we[i]    = 1'b1;
                    m_wdata[i] = 15;
                    m_waddr[i] = m_len[i];
                    m_mem[i][m_len[i]] = 15;
                end else if (e_en) begin
                    if (sw_op > 4'd7) begin
                        m_bad[i] = 1'b1;
                    end else if (m_len[i] < depth - 1) begin
                        m_we[i]    = 1'b1;
                        m_wdata[i] = int'(sw_op);
                        m_waddr[i] = m_len[i];
                        m_mem[i][m_len[i]] = int'(sw_op);
                        m_len[i]++;
                    end
                end
            end
            P_TERM:  m_ph[i] = P_READY;
            P_READY: begin
                if (e_clr) begin
                    m_len[i] = 0;
                    m_ph[i]  = P_LOAD;
                end else if (e_run) begin
                    m_ph[i]  = P_START;
                    m_go[i]  = 1'b1;
                    m_own[i] = 1'b0;
                end
            end
            P_START:  m_ph[i] = P_WAITLO;
            P_WAITLO: if (!ctrl_idle) m_ph[i] = P_RUN;
            P_RUN: begin
                if (ctrl_idle) begin
                    m_ph[i]  = P_READY;
                    m_own[i] = 1'b1;
                end
            end
            default: m_ph[i] = P_LOAD;
        endcase
    endtask

    // Model advances on every clock edge and resets asynchronously with the DUT.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hq_en.delete();
            hq_run.delete();
            hq_clr.delete();
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = P_LOAD;  m_len[i] = 0;  m_waddr[i] = 0;  m_wdata[i] = 0;
                m_we[i] = 1'b0;    m_go[i] = 1'b0; m_bad[i] = 1'b0; m_own[i] = 1'b1;
            end
        end else begin
            int n;
            bit e_en, e_run, e_clr;
            hq_en.push_back(key_enter);
            hq_run.push_back(key_run);
            hq_clr.push_back(key_clear);
            n = hq_en.size();
            e_en  = (n >= 5) ? edge_of(hq_en[n-4],  hq_en[n-5],  n) : 1'b0;
            e_run = (n >= 5) ? edge_of(hq_run[n-4], hq_run[n-5], n) : 1'b0;
            e_clr = (n >= 5) ? edge_of(hq_clr[n-4], hq_clr[n-5], n) : 1'b0;
            for (int i = 0; i < 2; i++) model_step(i, e_en, e_run, e_clr);
        end
    end

    // ---------------- DUT memory capture and pulse counters ----------------
    logic [3:0] dmem8 [256];
    logic [3:0] dmem2 [4];
    int wr_cnt[2], bad_cnt[2], go_cnt[2];

    always @(negedge clk) begin
        if (if8.prog_we) begin dmem8[if8.prog_addr] = if8.prog_wdata; wr_cnt[0]++; end
        if (if2.prog_we) begin dmem2[if2.prog_addr] = if2.prog_wdata; wr_cnt[1]++; end
        if (bad8) bad_cnt[0]++;
        if (bad2) bad_cnt[1]++;
        if (go8)  go_cnt[0]++;
        if (go2)  go_cnt[1]++;
    end

    // ---------------- per-cycle compare ----------------
    task automatic chk_inst(input int i, input int addr, input int wdata, input int we,
                            input int own, input int len, input int g, input int fl,
                            input int bad, input int st);
        int depth;
        depth = (i == 0) ? 256 : 4;
        check($sformatf("u%0d.prog_addr", i),  addr,  m_we[i] ? m_waddr[i] : m_len[i]);
        check($sformatf("u%0d.prog_wdata", i), wdata, m_wdata[i]);
        check($sformatf("u%0d.prog_we", i),    we,    int'(m_we[i]));
        check($sformatf("u%0d.prog_own", i),   own,   int'(m_own[i]));
        check($sformatf("u%0d.prog_len", i),   len,   m_len[i]);
        check($sformatf("u%0d.go", i),         g,     int'(m_go[i]));
        check($sformatf("u%0d.full", i),       fl,    int'(m_len[i] == depth - 1));
        check($sformatf("u%0d.bad_op", i),     bad,   int'(m_bad[i]));
        check($sformatf("u%0d.state_dbg", i),  st,    int'(m_ph[i]));
    endtask

    always @(negedge clk) begin
        chk_inst(0, 32'(if8.prog_addr), 32'(if8.prog_wdata), 32'(if8.prog_we),
                 32'(if8.prog_own), 32'(len8), 32'(go8), 32'(full8), 32'(bad8), 32'(st8));
        chk_inst(1, 32'(if2.prog_addr), 32'(if2.prog_wdata), 32'(if2.prog_we),
                 32'(if2.prog_own), 32'(len2), 32'(go2), 32'(full2), 32'(bad2), 32'(st2));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // k bit0 = ENTER, bit1 = RUN, bit2 = CLEAR; keys held for three samples.
    task automatic press(input logic [2:0] k, input logic [3:0] op);
        @(negedge clk);
        sw_op = op;
        key_enter = k[0]; key_run = k[1]; key_clear = k[2];
        cyc(3);
        key_enter = 1'b0; key_run = 1'b0; key_clear = 1'b0;
        cyc(5);
    endtask

    initial begin
        int w0, w1, b0, g0, mism;
        resetn = 1'b0; sw_op = 4'd0; ctrl_idle = 1'b1;
        key_enter = 1'b0; key_run = 1'b0; key_clear = 1'b0;
        for (int a = 0; a < 256; a++) begin dmem8[a] = 4'd0; m_mem[0][a] = 0; m_mem[1][a] = 0; end
        for (int a = 0; a < 4; a++) dmem2[a] = 4'd0;
        for (int i = 0; i < 2; i++) begin wr_cnt[i] = 0; bad_cnt[i] = 0; go_cnt[i] = 0; end
        cyc(3);
        check("rst_state", 32'(st8), 0);
        check("rst_own",   32'(if8.prog_own), 1);
        check("rst_full2", 32'(full2), 0);
        resetn = 1'b1;
        cyc(6);

        // 1: enter 2,2,6 then F
        press(3'b001, 4'd2); press(3'b001, 4'd2); press(3'b001, 4'd6); press(3'b001, 4'hF);
        check("t1_mem0", 32'(dmem8[0]), 2);
        check("t1_mem1", 32'(dmem8[1]), 2);
        check("t1_mem2", 32'(dmem8[2]), 6);
        check("t1_mem3", 32'(dmem8[3]), 15);
        check("t1_len",  32'(len8), 3);
        check("t1_state", 32'(st8), 2);

        // 2: RUN from READY, execution window, back to READY
        g0 = go_cnt[0];
        press(3'b010, 4'd0);
        check("t2_own_low", 32'(if8.prog_own), 0);
        ctrl_idle = 1'b0;
        cyc(5);
        check("t2_in_run", 32'(st8), 5);
        ctrl_idle = 1'b1;
        cyc(3);
        check("t2_go_pulses", go_cnt[0] - g0, 1);
        check("t2_ready", 32'(st8), 2);
        check("t2_own_back", 32'(if8.prog_own), 1);

        // 3: small memory fills after three opcodes; fourth is dropped; stop at top
        press(3'b100, 4'd0);
        press(3'b001, 4'd0); press(3'b001, 4'd1); press(3'b001, 4'd2);
        check("t3_full2", 32'(full2), 1);
        check("t3_full8", 32'(full8), 0);
        w0 = wr_cnt[0]; w1 = wr_cnt[1];
        press(3'b001, 4'd3);
        check("t3_nowrite2", wr_cnt[1] - w1, 0);
        check("t3_write8",   wr_cnt[0] - w0, 1);
        press(3'b010, 4'd0);
        check("t3_stop2", 32'(dmem2[3]), 15);
        check("t3_op8",   32'(dmem8[3]), 3);
        check("t3_stop8", 32'(dmem8[4]), 15);

        // 4: illegal opcode
        press(3'b100, 4'd0);
        b0 = bad_cnt[0]; w0 = wr_cnt[0];
        press(3'b001, 4'd9);
        check("t4_bad",   bad_cnt[0] - b0, 1);
        check("t4_nowr",  wr_cnt[0] - w0, 0);
        check("t4_addr",  32'(if8.prog_addr), 0);

        // 5: ENTER and CLEAR together after four writes
        press(3'b001, 4'd1); press(3'b001, 4'd2); press(3'b001, 4'd3); press(3'b001, 4'd4);
        check("t5_len_before", 32'(len8), 4);
        w0 = wr_cnt[0];
        press(3'b101, 4'd5);
        check("t5_nowr", wr_cnt[0] - w0, 0);
        check("t5_len",  32'(len8), 0);
        check("t5_addr", 32'(if8.prog_addr), 0);
        check("t5_len2", 32'(len2), 0);

        // 6: reset in RUN, key held across release
        press(3'b001, 4'd1); press(3'b001, 4'hF); press(3'b010, 4'd0);
        ctrl_idle = 1'b0;
        cyc(3);
        check("t6_in_run", 32'(st8), 5);
        sw_op = 4'd2; key_enter = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_state", 32'(st8), 0);
        check("t6_rst_own",   32'(if8.prog_own), 1);
        check("t6_rst_len",   32'(len8), 0);
        check("t6_rst_we",    32'(if8.prog_we), 0);
        ctrl_idle = 1'b1;
        cyc(2);
        resetn = 1'b1;
        w0 = wr_cnt[0];
        cyc(10);
        check("t6_nospurious", wr_cnt[0] - w0, 0);
        check("t6_mem_kept", 32'(dmem8[1]), 15);
        key_enter = 1'b0;
        cyc(4);
        press(3'b001, 4'd7);
        check("t6_alive_len", 32'(len8), 1);
        check("t6_alive_mem", 32'(dmem8[0]), 7);

        // Random phase: arbitrary key/switch/idle activity against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)  key_enter = ~key_enter;
            if ($urandom_range(0, 9) == 0)  key_run   = ~key_run;
            if ($urandom_range(0, 24) == 0) key_clear = ~key_clear;
            if ($urandom_range(0, 3) == 0)  sw_op     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0)  ctrl_idle = ~ctrl_idle;
        end
        key_enter = 1'b0; key_run = 1'b0; key_clear = 1'b0; ctrl_idle = 1'b1;
        cyc(12);

        mism = 0;
        for (int a = 0; a < 256; a++) if (int'(dmem8[a]) != m_mem[0][a]) mism++;
        check("mem8_image", mism, 0);
        mism = 0;
        for (int a = 0; a < 4; a++) if (int'(dmem2[a]) != m_mem[1][a]) mism++;
        check("mem2_image", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
